hv_similarity_search: RTL and testbench
=======================================

Name: hv_similarity_search

Overview:
Consumer end of the encoder output interface. Receives an encoded query hypervector as a stream of M_SIZE-dimension chunks, matching the encoder's out bus. Accumulates a signed dot product against N_CLASSES stored binary class hypervectors, then returns the best-matching class and its score. Sits downstream of the encoding/controller pair in the accelerator top as the inference back end.

Parameters:
Dhv_SIZE, 4000, hypervector dimension; must be a multiple of M_SIZE
M_SIZE, 16, dimensions per chunk; matches the encoder output width
DIM_WIDTH, 16, signed width of each query dimension
N_CLASSES, 8, number of stored class hypervectors
ACC_WIDTH, 32, signed accumulator/score width; must be ≥ DIM_WIDTH+$clog2(Dhv_SIZE)+1
CHUNKS, Dhv_SIZE/M_SIZE, derived localparam; 250 at defaults

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  query chunk valid
in_ready  out  1  block can accept a chunk
in_chunk  in  [M_SIZE-1:0][DIM_WIDTH-1:0]  signed query dimensions
in_last  in  1  final chunk of the query
cls_wr_en  in  1  class memory write strobe
cls_wr_class  in  $clog2(N_CLASSES)  class index to write
cls_wr_chunk  in  $clog2(CHUNKS)  chunk index to write
cls_wr_data  in  M_SIZE  class bits: 1 = +1, 0 = -1
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_class  out  $clog2(N_CLASSES)  argmax class
result_score  out  ACC_WIDTH  signed winning score
err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset: state IDLE; chunk_cnt=0; all accumulators 0; in_ready=1; result_valid=0; result_class=0; result_score=0; err=0. Class memory is not cleared.
- IDLE:
  - in_ready=1.
  - A handshake (in_valid&&in_ready) latches in_chunk and in_last, then moves to ACCUM with k=0.
- ACCUM (N_CLASSES cycles, in_ready=0):
  - In cycle k, acc[k] += sum over i of (bit i of class k, current chunk ? +x_i : -x_i), with x_i sign-extended to ACC_WIDTH.
  - After k=N_CLASSES-1: if the latched last bit is set or chunk_cnt==CHUNKS-1, go to SEARCH. Otherwise increment chunk_cnt and return to IDLE.
- Errors:
  - Pulse err if in_last arrives with chunk_cnt≠CHUNKS-1 (early last: the partial query is still searched).
  - Pulse err if chunk_cnt==CHUNKS-1 without in_last (query force-terminated).
- SEARCH (N_CLASSES cycles): sequential argmax over acc[0..N-1]. A candidate replaces the current best only if strictly greater, so ties resolve to the lowest index.
- DONE:
  - result_valid=1; result_class and result_score are stable while result_valid=1.
  - On result_ready=1, go to IDLE: clear result_valid, accumulators and chunk_cnt in the same edge.
  - in_ready=0 throughout DONE (backpressure).
- Latency: with the final chunk accepted at edge t, result_valid rises at edge t+2*N_CLASSES+1.
- Class writes:
  - Take effect only in IDLE with chunk_cnt==0.
  - Otherwise the write is dropped and err pulses.
  - A write at the same edge as a chunk handshake is applied, because both conditions hold at that edge.
- Reset mid-operation: asynchronously aborts any state and returns to the reset values above. The class memory contents persist.

Decomposition:
- Package hv_pkg:
  - typedef dim_t (signed DIM_WIDTH) and acc_t (signed ACC_WIDTH).
  - state enum {IDLE, ACCUM, SEARCH, DONE}.
  - function signed_chunk_dot(chunk, class_bits) returning acc_t.
- One natural sub-module: hv_class_mem.
  - N_CLASSES*CHUNKS words of M_SIZE bits.
  - Synchronous write; combinational read addressed by {k, chunk_cnt}.

Test Plan (bench params Dhv_SIZE=64, M_SIZE=16, N_CLASSES=4, so CHUNKS=4):
- Basic match:
  - Stimulus: load class 2 all ones, classes 0/1/3 all zeros; stream 4 chunks of all x_i=1 with in_last on chunk 3.
  - Required: result_class=2, result_score=64, result_valid at edge t+9.
- Tie and negative:
  - Stimulus: all classes identical (all zeros); query all x_i=3.
  - Required: result_class=0, result_score=-192.
- Backpressure:
  - Stimulus: hold result_ready=0 for 20 cycles; drive in_valid=1 throughout.
  - Required: result_valid, result_class and result_score stay constant; in_ready=0; no chunk accepted. After result_ready=1: IDLE, accumulators 0.
- Early last:
  - Stimulus: in_last on chunk 1.
  - Required: err pulses once; result computed over 2 chunks (score 32 in the basic-match setup).
- Write while busy:
  - Stimulus: cls_wr_en during ACCUM.
  - Required: err pulse; a following query shows class memory unchanged.
- Reset mid-ACCUM:
  - Stimulus: drop reset to 0 asynchronously.
  - Required: outputs go to reset values immediately; after release, a fresh query gives the basic-match result (memory retained).

Source files
------------

// File: rtl/hv_similarity_search_pkg.sv
// Shared types and the chunk dot-product helper for the hypervector similarity search back end.
// Chunk geometry is fixed here to match the encoder output bus.
package hv_pkg;

  localparam int HV_M_SIZE    = 16;
  localparam int HV_DIM_WIDTH = 16;
  localparam int HV_ACC_WIDTH = 32;

  typedef logic signed [HV_DIM_WIDTH-1:0] dim_t;
  typedef logic signed [HV_ACC_WIDTH-1:0] acc_t;
  typedef logic [HV_M_SIZE-1:0][HV_DIM_WIDTH-1:0] chunk_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Class bit 1 adds the sign-extended dimension, bit 0 subtracts it
  function automatic acc_t signed_chunk_dot(input chunk_t chunk, input logic [HV_M_SIZE-1:0] class_bits);
    acc_t sum;
    dim_t x;
    sum = '0;
    for (int i = 0; i < HV_M_SIZE; i++) begin
      x = dim_t'(chunk[i]);
      if (class_bits[i]) begin
        sum = sum + acc_t'(x);
      end else begin
        sum = sum - acc_t'(x);
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/hv_similarity_search_class_mem.sv
// Binary class hypervector store: one M_SIZE-bit word per (class, chunk).
// Synchronous write, combinational read; contents are deliberately not reset.
module hv_class_mem #(
  parameter int N_CLASSES = 8,
  parameter int CHUNKS    = 250,
  parameter int M_SIZE    = 16,
  parameter int CW        = 3,
  parameter int KW        = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_class,
  input  logic [KW-1:0]     wr_chunk,
  input  logic [M_SIZE-1:0] wr_data,
  input  logic [CW-1:0]     rd_class,
  input  logic [KW-1:0]     rd_chunk,
  output logic [M_SIZE-1:0] rd_data
);

  logic [M_SIZE-1:0] mem_r [N_CLASSES][CHUNKS];

  // Class word write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_class][wr_chunk] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_class][rd_chunk];

endmodule

// File: rtl/hv_similarity_search.sv
// Streams a query hypervector chunk by chunk, accumulates signed dot products
// against the stored class hypervectors, then reports the argmax class and score.
module hv_similarity_search
  import hv_pkg::*;
#(
  parameter int Dhv_SIZE  = 4000,
  parameter int M_SIZE    = HV_M_SIZE,
  parameter int DIM_WIDTH = HV_DIM_WIDTH,
  parameter int N_CLASSES = 8,
  parameter int ACC_WIDTH = HV_ACC_WIDTH,
  localparam int CHUNKS   = Dhv_SIZE / M_SIZE,
  localparam int CW       = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1,
  localparam int KW       = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [M_SIZE-1:0][DIM_WIDTH-1:0]   in_chunk,
  input  logic                               in_last,
  input  logic                               cls_wr_en,
  input  logic [CW-1:0]                      cls_wr_class,
  input  logic [KW-1:0]                      cls_wr_chunk,
  input  logic [M_SIZE-1:0]                  cls_wr_data,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic [CW-1:0]                      result_class,
  output logic [ACC_WIDTH-1:0]               result_score,
  output logic                               err
);

  localparam logic [CW-1:0] K_LAST   = CW'(N_CLASSES - 1);
  localparam logic [KW-1:0] CNT_LAST = KW'(CHUNKS - 1);

  state_t            state_r;
  state_t            next_state_s;
  logic [CW-1:0]     k_r;
  logic [KW-1:0]     chunk_cnt_r;
  chunk_t            chunk_r;
  logic              last_r;
  acc_t              acc_r [N_CLASSES];
  acc_t              best_score_r;
  logic [CW-1:0]     best_class_r;
  logic              in_ready_r;
  logic              result_valid_r;
  logic [CW-1:0]     result_class_r;
  acc_t              result_score_r;
  logic              err_r;

  logic [M_SIZE-1:0] class_bits_s;
  acc_t              dot_s;
  logic              handshake_s;
  logic              k_last_s;
  logic              cnt_last_s;
  logic              wr_ok_s;
  logic              mem_wr_en_s;
  logic              err_s;

  hv_class_mem #(
    .N_CLASSES (N_CLASSES),
    .CHUNKS    (CHUNKS),
    .M_SIZE    (M_SIZE),
    .CW        (CW),
    .KW        (KW)
  ) u_class_mem (
    .clk      (clk),
    .wr_en    (mem_wr_en_s),
    .wr_class (cls_wr_class),
    .wr_chunk (cls_wr_chunk),
    .wr_data  (cls_wr_data),
    .rd_class (k_r),
    .rd_chunk (chunk_cnt_r),
    .rd_data  (class_bits_s)
  );

  assign dot_s = signed_chunk_dot(chunk_r, class_bits_s);

  // Handshake, write-permission and protocol-error decode
  always_comb begin
    handshake_s = in_valid && in_ready_r;
    k_last_s    = (k_r == K_LAST);
    cnt_last_s  = (chunk_cnt_r == CNT_LAST);
    wr_ok_s     = (state_r == IDLE) && (chunk_cnt_r == '0);
    mem_wr_en_s = cls_wr_en && wr_ok_s;
    // A last flag that disagrees with the chunk position is an early or missing terminator
    err_s       = (cls_wr_en && !wr_ok_s) || (handshake_s && (in_last != cnt_last_s));
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (handshake_s) begin
          next_state_s = ACCUM;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCUM: begin
        if (!k_last_s) begin
          next_state_s = ACCUM;
        end else if (last_r || cnt_last_s) begin
          next_state_s = SEARCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      SEARCH: begin
        if (k_last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SEARCH;
        end
      end
      DONE: begin
        if (result_valid_r && result_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      k_r            <= '0;
      chunk_cnt_r    <= '0;
      chunk_r        <= '0;
      last_r         <= 1'b0;
      best_score_r   <= '0;
      best_class_r   <= '0;
      in_ready_r     <= 1'b1;
      result_valid_r <= 1'b0;
      result_class_r <= '0;
      result_score_r <= '0;
      err_r          <= 1'b0;
      for (int c = 0; c < N_CLASSES; c++) begin
        acc_r[c] <= '0;
      end
    end else begin
      state_r    <= next_state_s;
      in_ready_r <= (next_state_s == IDLE);
      err_r      <= err_s;
      case (state_r)
        IDLE: begin
          if (handshake_s) begin
            chunk_r <= in_chunk;
            last_r  <= in_last;
            k_r     <= '0;
          end
        end
        ACCUM: begin
          acc_r[k_r] <= acc_r[k_r] + dot_s;
          k_r        <= k_last_s ? '0 : k_r + CW'(1);
          if (k_last_s && !(last_r || cnt_last_s)) begin
            chunk_cnt_r <= chunk_cnt_r + KW'(1);
          end
        end
        SEARCH: begin
          // Strictly-greater replacement keeps the lowest index on ties
          if ((k_r == '0) || (acc_r[k_r] > best_score_r)) begin
            best_score_r <= acc_r[k_r];
            best_class_r <= k_r;
          end
          k_r <= k_last_s ? '0 : k_r + CW'(1);
        end
        DONE: begin
          if (!result_valid_r) begin
            result_valid_r <= 1'b1;
            result_class_r <= best_class_r;
            result_score_r <= best_score_r;
          end else if (result_ready) begin
            result_valid_r <= 1'b0;
            chunk_cnt_r    <= '0;
            for (int c = 0; c < N_CLASSES; c++) begin
              acc_r[c] <= '0;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign result_valid = result_valid_r;
  assign result_class = result_class_r;
  assign result_score = result_score_r;
  assign err          = err_r;

endmodule

// File: tb/tb_hv_similarity_search.sv
// Randomized self-checking bench for hv_similarity_search against a plain-arithmetic
// dot-product/argmax reference model (Dhv_SIZE=64, M_SIZE=16, N_CLASSES=4).
module tb_hv_similarity_search;

  localparam int DHV = 64;
  localparam int M   = 16;
  localparam int DW  = 16;
  localparam int NC  = 4;
  localparam int AW  = 32;
  localparam int CH  = DHV / M;

  typedef logic [M-1:0][DW-1:0] qchunk_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  qchunk_t           in_chunk = '0;
  logic              in_last = 1'b0;
  logic              cls_wr_en = 1'b0;
  logic [1:0]        cls_wr_class = 2'd0;
  logic [1:0]        cls_wr_chunk = 2'd0;
  logic [M-1:0]      cls_wr_data = '0;
  logic              result_valid;
  logic              result_ready = 1'b0;
  logic [1:0]        result_class;
  logic [AW-1:0]     result_score;
  logic              err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  logic [M-1:0] cls_m [NC][CH];
  qchunk_t      q_m [CH];

  hv_similarity_search #(
    .Dhv_SIZE  (DHV),
    .M_SIZE    (M),
    .DIM_WIDTH (DW),
    .N_CLASSES (NC),
    .ACC_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_chunk     (in_chunk),
    .in_last      (in_last),
    .cls_wr_en    (cls_wr_en),
    .cls_wr_class (cls_wr_class),
    .cls_wr_chunk (cls_wr_chunk),
    .cls_wr_data  (cls_wr_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_class (result_class),
    .result_score (result_score),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err === 1'b1) err_seen++;
  end

  task automatic check_eq(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_class(input int c, input int j, input logic [M-1:0] d, input bit update);
    cls_wr_en    = 1'b1;
    cls_wr_class = 2'(c);
    cls_wr_chunk = 2'(j);
    cls_wr_data  = d;
    @(negedge clk);
    cls_wr_en = 1'b0;
    if (update) cls_m[c][j] = d;
  endtask

  task automatic load_basic();
    for (int c = 0; c < NC; c++)
      for (int j = 0; j < CH; j++)
        write_class(c, j, (c == 2) ? 16'hFFFF : 16'h0000, 1'b1);
  endtask

  task automatic load_random();
    for (int c = 0; c < NC; c++)
      for (int j = 0; j < CH; j++)
        write_class(c, j, 16'($urandom), 1'b1);
  endtask

  task automatic fill_query(input int v);
    logic [31:0] w;
    w = 32'(v);
    for (int j = 0; j < CH; j++)
      for (int i = 0; i < M; i++) q_m[j][i] = w[15:0];
  endtask

  // Reference: score[c] = sum over accepted chunks and dims of (+x or -x), first strict maximum wins
  function automatic void model(input int nch, output int exp_cls, output logic signed [63:0] exp_score);
    logic signed [63:0] s;
    logic signed [63:0] x;
    exp_cls = 0;
    exp_score = 0;
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int j = 0; j < nch; j++)
        for (int i = 0; i < M; i++) begin
          x = $signed(q_m[j][i]);
          s = cls_m[c][j][i] ? s + x : s - x;
        end
      if (c == 0 || s > exp_score) begin
        exp_score = s;
        exp_cls = c;
      end
    end
  endfunction

  task automatic send_chunk(input qchunk_t ch, input bit last);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_chunk = ch;
    in_last  = last;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check_eq("in_ready_timeout", w, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_query(input string tag, input int nch, input int hold, input int wr_busy_at);
    int ecls;
    logic signed [63:0] escore;
    int base;
    int n;
    int exp_err;
    base = err_seen;
    model(nch, ecls, escore);
    exp_err = (nch != CH) ? 1 : 0;
    for (int j = 0; j < nch; j++) begin
      send_chunk(q_m[j], j == nch - 1);
      if (j == wr_busy_at) begin
        write_class(2, 1, ~cls_m[2][1], 1'b0);
        exp_err++;
      end
    end
    n = 0;
    while (result_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_latency"}, n, 2 * NC + 1);
    check_eq({tag, "_class"}, result_class, ecls);
    check_eq({tag, "_score"}, $signed(result_score), escore);
    in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      for (int i = 0; i < M; i++) in_chunk[i] = 16'($urandom);
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, result_valid, 1);
      check_eq({tag, "_hold_class"}, result_class, ecls);
      check_eq({tag, "_hold_score"}, $signed(result_score), escore);
      check_eq({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check_eq({tag, "_valid_clr"}, result_valid, 0);
    check_eq({tag, "_idle_ready"}, in_ready, 1);
    check_eq({tag, "_err_count"}, err_seen - base, exp_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "simulation stalled");
  end

  initial begin
    int v;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_result_valid", result_valid, 0);
    check_eq("rst_result_class", result_class, 0);
    check_eq("rst_result_score", $signed(result_score), 0);
    check_eq("rst_err", err, 0);
    reset = 1'b1;
    @(negedge clk);

    load_basic();
    fill_query(1);
    do_query("basic", CH, 0, -1);
    do_query("backpressure", CH, 20, -1);

    for (int c = 0; c < NC; c++)
      for (int j = 0; j < CH; j++) write_class(c, j, 16'h0000, 1'b1);
    fill_query(3);
    do_query("tie_neg", CH, 2, -1);

    load_basic();
    fill_query(1);
    do_query("early_last", 2, 0, -1);
    do_query("busy_write", CH, 0, 0);
    do_query("after_busy", CH, 0, -1);

    send_chunk(q_m[0], 1'b0);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_result_valid", result_valid, 0);
    check_eq("midrst_result_score", $signed(result_score), 0);
    check_eq("midrst_result_class", result_class, 0);
    check_eq("midrst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_query("post_reset", CH, 0, -1);

    for (int it = 0; it < 8; it++) begin
      load_random();
      for (int j = 0; j < CH; j++)
        for (int i = 0; i < M; i++) begin
          v = int'($urandom_range(0, 4000)) - 2000;
          q_m[j][i] = v[15:0];
        end
      do_query("random", (it == 5) ? 3 : CH, int'($urandom_range(0, 3)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
